// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and requester indices for the register-file write arbiter.
`default_nettype none

package regfile_pkg;
   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      REQ_WB = 1'b0,
      REQ_MC = 1'b1
   } req_idx_e;
endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with issue set, completion clear and source lookups.
`default_nettype none

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  clear_en,
   input  logic [REG_ADDR_W-1:0] clear_addr,
   output logic                  clear_busy,
   input  logic [REG_ADDR_W-1:0] rs1_address,
   input  logic [REG_ADDR_W-1:0] rs2_address,
   input  logic                  pending_write,
   input  logic [REG_ADDR_W-1:0] pending_rd,
   output logic                  rs1_busy,
   output logic                  rs2_busy
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic                set_en;

   assign issue_ready = !busy[issue_rd] || (issue_rd == '0);
   assign set_en      = issue_valid && issue_ready && (issue_rd != '0);
   assign clear_busy  = busy[clear_addr];

   // A source still counts as busy while its completing write sits in the output register.
   assign rs1_busy = (rs1_address != '0) &&
                     (busy[rs1_address] || (pending_write && pending_rd == rs1_address));
   assign rs2_busy = (rs2_address != '0) &&
                     (busy[rs2_address] || (pending_write && pending_rd == rs2_address));

   always_comb begin
      busy_next = busy;
      if (clear_en) busy_next[clear_addr] = 1'b0;
      // Set is applied after clear so a same-edge issue to the same register wins.
      if (set_en)   busy_next[issue_rd]   = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) busy <= '0;
      else          busy <= busy_next;
   end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbitration of writeback and multi-cycle completions onto one
// register-file write port, with a WAW/RAW busy scoreboard.
`default_nettype none

module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int XLEN     = regfile_pkg::XLEN,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  wb_ready,
   input  logic                  mc_valid,
   input  logic [REG_ADDR_W-1:0] mc_rd,
   input  logic [XLEN-1:0]       mc_data,
   output logic                  mc_ready,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic [REG_ADDR_W-1:0] rs1_address,
   input  logic [REG_ADDR_W-1:0] rs2_address,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] rd_address,
   output logic [XLEN-1:0]       write_data,
   output logic                  sb_error
);

   req_idx_e last_grant;
   logic     wb_xfer;
   logic     mc_xfer;
   logic     mc_busy;

   // Grant depends only on valids and the pointer, never on data.
   assign wb_ready = wb_valid && (!mc_valid || last_grant == REQ_MC);
   assign mc_ready = mc_valid && (!wb_valid || last_grant == REQ_WB);
   assign wb_xfer  = wb_valid && wb_ready;
   assign mc_xfer  = mc_valid && mc_ready;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clock         (clock),
      .reset_n       (reset_n),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .issue_ready   (issue_ready),
      .clear_en      (mc_xfer),
      .clear_addr    (mc_rd),
      .clear_busy    (mc_busy),
      .rs1_address   (rs1_address),
      .rs2_address   (rs2_address),
      .pending_write (reg_write),
      .pending_rd    (rd_address),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         reg_write  <= 1'b0;
         rd_address <= '0;
         write_data <= '0;
         last_grant <= REQ_MC;
         sb_error   <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         if (wb_xfer) begin
            last_grant <= REQ_WB;
            if (wb_rd != '0) begin
               reg_write  <= 1'b1;
               rd_address <= wb_rd;
               write_data <= wb_data;
            end
         end else if (mc_xfer) begin
            last_grant <= REQ_MC;
            if (mc_rd != '0) begin
               reg_write  <= 1'b1;
               rd_address <= mc_rd;
               write_data <= mc_data;
            end
         end
         // Completion for a register never issued: flag it but still perform the write.
         if (mc_xfer && mc_rd != '0 && !mc_busy) sb_error <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table with a write-expectation queue, plus an async reset sequence.
`default_nettype none

module tb_regfile_write_arbiter;

   localparam int XLEN = 64;
   localparam int NV   = 21;

   logic            clock;
   logic            reset_n;
   logic            wb_valid, mc_valid, issue_valid;
   logic [4:0]      wb_rd, mc_rd, issue_rd, rs1_address, rs2_address;
   logic [XLEN-1:0] wb_data, mc_data;
   logic            wb_ready, mc_ready, issue_ready, rs1_busy, rs2_busy;
   logic            reg_write, sb_error;
   logic [4:0]      rd_address;
   logic [XLEN-1:0] write_data;

   regfile_write_arbiter #(.XLEN(XLEN), .NUM_REGS(32)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_ready    (wb_ready),
      .mc_valid    (mc_valid),
      .mc_rd       (mc_rd),
      .mc_data     (mc_data),
      .mc_ready    (mc_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .rs1_address (rs1_address),
      .rs2_address (rs2_address),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .reg_write   (reg_write),
      .rd_address  (rd_address),
      .write_data  (write_data),
      .sb_error    (sb_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       wv;  logic [4:0] wrd; logic [63:0] wd;
      logic       mv;  logic [4:0] mrd; logic [63:0] md;
      logic       iv;  logic [4:0] ird;
      logic [4:0] rs1; logic [4:0] rs2;
      logic       e_wr; logic e_mr; logic e_ir; logic e_b1; logic e_b2; logic e_err;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   vec_t vecs [0:NV-1];
   wr_t  exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      rs1_address = '0; rs2_address = '0;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      wr_t  e;
      v = vecs[i];
      @(negedge clock);
      wb_valid = v.wv; wb_rd = v.wrd; wb_data = v.wd;
      mc_valid = v.mv; mc_rd = v.mrd; mc_data = v.md;
      issue_valid = v.iv; issue_rd = v.ird;
      rs1_address = v.rs1; rs2_address = v.rs2;
      #1;
      check($sformatf("v%0d wb_ready", i),    64'(wb_ready),    64'(v.e_wr));
      check($sformatf("v%0d mc_ready", i),    64'(mc_ready),    64'(v.e_mr));
      check($sformatf("v%0d issue_ready", i), 64'(issue_ready), 64'(v.e_ir));
      check($sformatf("v%0d rs1_busy", i),    64'(rs1_busy),    64'(v.e_b1));
      check($sformatf("v%0d rs2_busy", i),    64'(rs2_busy),    64'(v.e_b2));
      check($sformatf("v%0d sb_error", i),    64'(sb_error),    64'(v.e_err));
      if (v.e_wr && v.wrd != 5'd0) exp_q.push_back('{v.wrd, v.wd});
      if (v.e_mr && v.mrd != 5'd0) exp_q.push_back('{v.mrd, v.md});
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("v%0d reg_write", i),  64'(reg_write),  64'd1);
         check($sformatf("v%0d rd_address", i), 64'(rd_address), 64'(e.rd));
         check($sformatf("v%0d write_data", i), write_data,      e.data);
      end else begin
         check($sformatf("v%0d reg_write idle", i), 64'(reg_write), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          wv    wrd    wd         mv    mrd     md          iv    ird    rs1    rs2     wr    mr    ir    b1    b2    err
      vecs[0]  = '{1'b1, 5'd5,  64'hA5,   1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd7,  64'h77,   1'b1, 5'd12, 5'd7,  5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd13, 5'd7,  5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 5'd1,  64'h11,   1'b1, 5'd12, 64'h1212, 1'b0, 5'd0,  5'd7,  5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 5'd2,  64'h22,   1'b1, 5'd12, 64'h1212, 1'b0, 5'd0,  5'd1,  5'd13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 5'd2,  64'h22,   1'b1, 5'd13, 64'h1313, 1'b0, 5'd0,  5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 5'd3,  64'h33,   1'b1, 5'd13, 64'h1313, 1'b0, 5'd0,  5'd2,  5'd13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd13, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 5'd0,  64'hFF,   1'b0, 5'd0,  64'h0,    1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd3,  64'h3333, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  64'h99,   1'b1, 5'd9,  5'd3,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd9,  5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[17] = '{1'b1, 5'd20, 64'hDEAD, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      // After the mid-operation reset: scoreboard empty, wb wins the first contention.
      vecs[18] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd9,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 5'd4,  64'h44,   1'b1, 5'd5,  64'h55,   1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd4,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      reset_n = 1'b0;
      drive_idle();
      #1;
      check("reset reg_write",  64'(reg_write),  64'd0);
      check("reset rd_address", 64'(rd_address), 64'd0);
      check("reset write_data", write_data,      64'd0);
      check("reset sb_error",   64'(sb_error),   64'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i <= 17; i++) run_vec(i);

      // Vector 17 left a write in the output register; drop reset asynchronously mid-cycle.
      #2;
      drive_idle();
      rs1_address = 5'd9;
      issue_rd    = 5'd9;
      reset_n     = 1'b0;
      #1;
      check("async reset reg_write",   64'(reg_write),   64'd0);
      check("async reset rd_address",  64'(rd_address),  64'd0);
      check("async reset write_data",  write_data,       64'd0);
      check("async reset sb_error",    64'(sb_error),    64'd0);
      check("async reset rs1_busy",    64'(rs1_busy),    64'd0);
      check("async reset issue_ready", 64'(issue_ready), 64'd1);
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      for (int i = 18; i < NV; i++) run_vec(i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameters: XLEN, default 64, data width; NUM_REGS, default 32, register count (address width 5).
REQ-002 SHALL have the following ports, one per line: name  direction  width  meaning.
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid / wb_rd / wb_data / wb_ready  in/in/in/out  1/5/XLEN/1  requester 0: single-cycle pipeline writeback.
- mc_valid / mc_rd / mc_data / mc_ready  in/in/in/out  1/5/XLEN/1  requester 1: multi-cycle unit (div/load) completion.
- issue_valid / issue_rd / issue_ready  in/in/out  1/5/1  multi-cycle op issue; reserves issue_rd.
- rs1_address / rs2_address  in  5 each  decode-stage source addresses.
- rs1_busy / rs2_busy  out  1 each  source has a pending write; decode stalls.
- reg_write / rd_address / write_data  out  1/5/XLEN  registered drive to the register file write port.
- sb_error  out  1  sticky protocol-violation flag.

Function
REQ-003 SHALL grant at most one of wb/mc per cycle; a transfer occurs when valid && ready are both high at a rising edge.
REQ-004 SHALL compute grant combinationally: with one requester valid, grant it; with both valid, grant the requester not granted most recently.
REQ-005 SHALL update the last-grant pointer only on a completed transfer; ready SHALL never be high while that requester's valid is low.
REQ-006 SHALL register a granted transfer: it appears on reg_write/rd_address/write_data in the next cycle (latency 1), and it is written into the register file on the following edge.
REQ-007 SHALL deassert reg_write in any cycle after an edge with no transfer; rd_address/write_data hold their last values.
REQ-008 SHALL accept and silently drop transfers with rd == 0: ready is asserted, and reg_write stays low the next cycle.
REQ-009 SHALL hold a NUM_REGS-bit busy scoreboard; bit 0 is hardwired 0.
REQ-010 SHALL set busy[issue_rd] on an edge where issue_valid && issue_ready && issue_rd != 0.
REQ-011 SHALL assert issue_ready = !busy[issue_rd] || issue_rd == 0 (WAW stall), independent of arbitration.
REQ-012 SHALL clear busy[mc_rd] on an mc transfer; if an issue sets the same address on the same edge, set SHALL win.
REQ-013 SHALL set sb_error (sticky until reset) on an mc transfer with mc_rd != 0 and busy[mc_rd] == 0; that write SHALL still be performed.
REQ-014 SHALL drive rsN_busy = (rsN_address != 0) && (busy[rsN_address] || (reg_write && rd_address == rsN_address)).
REQ-015 SHALL apply wb transfers without touching the scoreboard.

Reset
REQ-016 SHALL, while reset_n is low, asynchronously force the following: reg_write 0, rd_address 0, write_data 0, all busy bits 0, sb_error 0, and the last-grant pointer set to mc (so wb wins the first contention).
REQ-017 SHALL discard any in-flight registered write on reset mid-operation; no reg_write pulse SHALL follow reset deassertion without a new transfer.

Structure
REQ-018 SHALL place XLEN, REG_ADDR_W = 5, NUM_REGS = 32 and the requester-index enum (REQ_WB, REQ_MC) in shared package regfile_pkg.
REQ-019 SHALL implement the busy-bit array, set/clear logic and busy lookups in one sub-module, regfile_scoreboard; the arbitration and output register SHALL stay in the top level.
REQ-020 SHALL be purely synchronous apart from reset, with no combinational path from write_data to any ready.

Verification
REQ-021 The bench SHALL cover solo wb: wb_valid with rd=5, data=0xA5 -> wb_ready=1; next cycle reg_write=1, rd_address=5, write_data=0xA5; the cycle after, reg_write=0.
REQ-022 The bench SHALL cover contention: wb and mc valid for 4 cycles (mc_rd previously issued) -> grants alternate wb, mc, wb, mc; each loser's ready=0 that cycle.
REQ-023 The bench SHALL cover the scoreboard: issue rd=7 -> rs1_address=7 gives rs1_busy=1; a second issue to rd=7 -> issue_ready=0; mc transfer to rd=7 -> rs1_busy=1 for one more cycle (output reg), then 0.
REQ-024 The bench SHALL cover x0: wb rd=0, data=0xFF -> wb_ready=1, no reg_write; issue rd=0 -> issue_ready=1, rs1_address=0 gives rs1_busy=0.
REQ-025 The bench SHALL cover error and collision: mc transfer to non-busy rd=3 -> sb_error=1 and stays set, with the write performed; a same-edge issue and mc completion on rd=9 -> busy[9] remains 1.
REQ-026 The bench SHALL cover reset mid-operation: pull reset_n low asynchronously while reg_write=1 -> outputs, busy bits and sb_error go 0 immediately; after release, the first contention is granted to wb.
